// File: rtl/gpio_loopback_tester.sv
// Multi-channel GPIO loopback tester: drives a binary-weighted square wave on each
// output pin and scores the synchronised looped-back pin, reporting lock and error counts.
`timescale 1ns/1ps
module gpio_loopback_tester #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned ERR_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [DIV_WIDTH-1:0]          half_period,
    output logic [CHANNELS-1:0]           pat_out,
    input  logic [CHANNELS-1:0]           pat_in,
    output logic [CHANNELS-1:0]           locked,
    output logic [CHANNELS*ERR_WIDTH-1:0] err_count
);

    localparam int unsigned           MCNT_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [DIV_WIDTH-1:0]  HP_MIN    = DIV_WIDTH'(4);
    localparam logic [MCNT_W-1:0]     MCNT_LAST = MCNT_W'(LOCK_COUNT - 1);
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = {ERR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACQUIRE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    logic                 run_q;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] hp_c, hp_last_c;
    logic [CHANNELS-1:0]  phase_q, phase_d;
    logic                 tick_c;

    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]  sin_c;
    logic [CHANNELS-1:0]  match_c;

    state_t               state_q [CHANNELS];
    state_t               state_d [CHANNELS];
    logic [MCNT_W-1:0]    mcnt_q  [CHANNELS];
    logic [MCNT_W-1:0]    mcnt_d  [CHANNELS];
    logic [ERR_WIDTH-1:0] err_q   [CHANNELS];
    logic [ERR_WIDTH-1:0] err_d   [CHANNELS];
    logic [CHANNELS-1:0]  scnt_q, scnt_d;
    logic [CHANNELS-1:0]  locked_q, locked_d;
    logic [CHANNELS-1:0]  err_inc_c;

    // Divider and pattern counter; run_q holds div_cnt at 0 on the first enabled edge.
    always_comb begin
        hp_c      = (half_period < HP_MIN) ? HP_MIN : half_period;
        hp_last_c = hp_c - DIV_WIDTH'(1);
        tick_c    = enable & run_q & (div_cnt_q >= hp_last_c);
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        phase_d   = phase_q;
        if (!enable || !run_q || tick_c) begin
            div_cnt_d = '0;
        end
        if (!enable) begin
            phase_d = '0;
        end else if (tick_c) begin
            phase_d = phase_q + CHANNELS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q     <= 1'b0;
            div_cnt_q <= '0;
            phase_q   <= '0;
        end else begin
            run_q     <= enable;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Metastability synchroniser on the asynchronous return pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pat_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sin_c   = sync_q[SYNC_STAGES-1];
    assign match_c = ~(sin_c ^ phase_q);

    // Per-channel checker FSM; compares against the level driven over the elapsed half-period.
    always_comb begin
        err_inc_c = '0;
        scnt_d    = scnt_q;
        locked_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            mcnt_d[i]  = mcnt_q[i];
            err_d[i]   = err_q[i];
            if (!enable) begin
                state_d[i] = IDLE;
                mcnt_d[i]  = '0;
                scnt_d[i]  = 1'b0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        state_d[i] = SETTLE;
                        mcnt_d[i]  = '0;
                        scnt_d[i]  = 1'b0;
                    end
                    SETTLE: begin
                        if (tick_c) begin
                            scnt_d[i] = ~scnt_q[i];
                            if (scnt_q[i]) begin
                                state_d[i] = ACQUIRE;
                            end
                        end
                    end
                    ACQUIRE: begin
                        if (tick_c) begin
                            if (match_c[i]) begin
                                mcnt_d[i] = mcnt_q[i] + MCNT_W'(1);
                                if (mcnt_q[i] == MCNT_LAST) begin
                                    state_d[i] = LOCKED;
                                end
                            end else begin
                                mcnt_d[i]    = '0;
                                err_inc_c[i] = 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (tick_c && !match_c[i]) begin
                            state_d[i]   = ACQUIRE;
                            mcnt_d[i]    = '0;
                            err_inc_c[i] = 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                    end
                endcase
            end
            locked_d[i] = (state_d[i] == LOCKED);
            // Clear wins over a same-cycle increment; counters saturate.
            if (clear) begin
                err_d[i] = '0;
            end else if (err_inc_c[i] && (err_q[i] != ERR_MAX)) begin
                err_d[i] = err_q[i] + ERR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                mcnt_q[i]  <= '0;
                err_q[i]   <= '0;
            end
            scnt_q   <= '0;
            locked_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                mcnt_q[i]  <= mcnt_d[i];
                err_q[i]   <= err_d[i];
            end
            scnt_q   <= scnt_d;
            locked_q <= locked_d;
        end
    end

    assign pat_out = phase_q;
    assign locked  = locked_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_err
        assign err_count[g*ERR_WIDTH +: ERR_WIDTH] = err_q[g];
    end

endmodule

// File: tb/tb_gpio_loopback_tester.sv
// Scoreboard bench for gpio_loopback_tester: directed wiring faults with hand-computed
// expected pattern, lock and error-count snapshots checked by a separate monitor.
`timescale 1ns/1ps
module tb_gpio_loopback_tester;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned EW = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             clear;
    logic [DW-1:0]    half_period;
    logic [CH-1:0]    pat_out;
    logic [CH-1:0]    pat_in;
    logic [CH-1:0]    locked;
    logic [CH*EW-1:0] err_count;

    logic [CH-1:0]    stuck0_m, stuck1_m, inv_m, loop_v;
    logic             swap01;

    typedef struct {
        logic [95:0] name;
        logic [3:0]  pat;
        logic [3:0]  lck;
        logic [15:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   e_idx    = 0;

    gpio_loopback_tester #(
        .CHANNELS   (CH),
        .DIV_WIDTH  (DW),
        .SYNC_STAGES(2),
        .LOCK_COUNT (8),
        .ERR_WIDTH  (EW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .half_period(half_period),
        .pat_out    (pat_out),
        .pat_in     (pat_in),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #4 clk = ~clk;

    // Board wiring model: loopback with optional swap, stuck and inverted pins.
    always_comb begin
        loop_v = pat_out;
        if (swap01) begin
            loop_v[0] = pat_out[1];
            loop_v[1] = pat_out[0];
        end
        pat_in = ((loop_v & ~stuck0_m) | stuck1_m) ^ inv_m;
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (pat_out !== e.pat) begin
                n_errs++;
                $display("FAIL %0s pat_out got=%h exp=%h", e.name, pat_out, e.pat);
            end
            n_checks++;
            if (locked !== e.lck) begin
                n_errs++;
                $display("FAIL %0s locked got=%h exp=%h", e.name, locked, e.lck);
            end
            n_checks++;
            if (err_count !== e.err) begin
                n_errs++;
                $display("FAIL %0s err_count got=%h exp=%h", e.name, err_count, e.err);
            end
        end
    end

    task automatic push(input logic [95:0] nm, input logic [3:0] p,
                        input logic [3:0] l, input logic [15:0] er);
        exp_t e;
        e.name = nm;
        e.pat  = p;
        e.lck  = l;
        e.err  = er;
        exp_q.push_back(e);
    endtask

    // Advance to 1 ns after edge n, where edge 0 is the first edge that sees enable=1.
    task automatic to_edge(input int n);
        repeat (n - e_idx) @(posedge clk);
        #1;
        e_idx = n;
    endtask

    task automatic start_run();
        @(posedge clk);
        #1;
        enable = 1'b1;
        e_idx  = -1;
    endtask

    task automatic stop_run();
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        clear       = 1'b0;
        half_period = 16'd16;
        stuck0_m    = '0;
        stuck1_m    = '0;
        inv_m       = '0;
        swap01      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push("reset", 4'h0, 4'h0, 16'h0000);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Clean loopback: lock completes on tick 10 (edge 160).
        start_run();
        to_edge(159);  push("clean_pre",  4'h9, 4'h0, 16'h0000);
        to_edge(160);  push("clean_lock", 4'hA, 4'hF, 16'h0000);
        to_edge(288);  push("clean_run",  4'h2, 4'hF, 16'h0000);
        stop_run();
        pulse_clear();

        // Channel 2 stuck low: 4 errors per 8 ticks.
        stuck0_m = 4'b0100;
        start_run();
        to_edge(160);  push("stuck_a",    4'hA, 4'hB, 16'h0400);
        to_edge(288);  push("stuck_b",    4'h2, 4'hB, 16'h0800);
        stop_run();
        push("err_hold", 4'h0, 4'h0, 16'h0800);
        pulse_clear();
        push("clear_a", 4'h0, 4'h0, 16'h0000);
        stuck0_m = '0;

        // Channels 0 and 1 crossed.
        swap01 = 1'b1;
        start_run();
        to_edge(160);  push("cross_a",    4'hA, 4'hC, 16'h0044);
        to_edge(288);  push("cross_b",    4'h2, 4'hC, 16'h0088);
        stop_run();
        pulse_clear();
        push("clear_b", 4'h0, 4'h0, 16'h0000);
        swap01 = 1'b0;

        // Channel 0 open (reads 1): saturation, then clear on a mismatching tick.
        stuck1_m = 4'b0001;
        start_run();
        to_edge(1600); push("sat",        4'h4, 4'hE, 16'h000F);
        to_edge(1615); push("sat_hold",   4'h4, 4'hE, 16'h000F);
        clear = 1'b1;
        to_edge(1616); push("clr_tick",   4'h5, 4'hE, 16'h0000);
        clear = 1'b0;
        to_edge(1647); push("resume_pre", 4'h6, 4'hE, 16'h0000);
        to_edge(1648); push("resume",     4'h7, 4'hE, 16'h0001);
        stop_run();
        pulse_clear();
        push("clear_c", 4'h0, 4'h0, 16'h0000);
        stuck1_m = '0;

        // Clamped divider (ticks every 4 cycles) and a single injected mismatch.
        half_period = 16'd1;
        start_run();
        to_edge(39);   push("clamp_pre",  4'h9, 4'h0, 16'h0000);
        to_edge(40);   push("clamp_lock", 4'hA, 4'hF, 16'h0000);
        to_edge(41);   push("inj_pre",    4'hA, 4'hF, 16'h0000);
        inv_m = 4'b0001;
        to_edge(42);
        inv_m = 4'b0000;
        to_edge(43);   push("inj_wait",   4'hA, 4'hF, 16'h0000);
        to_edge(44);   push("inj_drop",   4'hB, 4'hE, 16'h0001);
        to_edge(75);   push("relock_pre", 4'h2, 4'hE, 16'h0001);
        to_edge(76);   push("relock",     4'h3, 4'hF, 16'h0001);

        // Asynchronous reset mid-run, then a long idle with enable low.
        to_edge(80);
        reset_n = 1'b0;
        push("rst_mid", 4'h0, 4'h0, 16'h0000);
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        push("idle_1000", 4'h0, 4'h0, 16'h0000);

        // Resume after reset goes through IDLE and SETTLE again.
        start_run();
        to_edge(39);   push("again_pre",  4'h9, 4'h0, 16'h0000);
        to_edge(40);   push("again_lock", 4'hA, 4'hF, 16'h0000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_loopback_tester.md
# gpio_loopback_tester

Multi-channel GPIO loopback pattern generator and checker, the parametrised successor to the single-pin toggle/compare test logic in the Arty top level. Each channel drives a distinct-frequency square wave on an output pin and checks the looped-back input pin. The checker reports per-channel lock status and saturating mismatch counts, so stuck, open and shorted (crossed) PMOD wiring can be detected at board bring-up. It sits in the 125 MHz core clock domain beside the debounce and sync logic.

## Interface
Parameters:
- CHANNELS, 4: number of output/input pin pairs (1..16).
- DIV_WIDTH, 16: width of the half-period divider.
- SYNC_STAGES, 2: synchroniser flops on each pat_in bit (≥2).
- LOCK_COUNT, 8: consecutive matching checks required to lock (≥1).
- ERR_WIDTH, 16: per-channel error counter width.

Ports:
- clk  in  1  core clock, 125 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high runs generator and checker.
- clear  in  1  single-cycle pulse; zeroes all error counters.
- half_period  in  DIV_WIDTH  tick spacing in clk cycles; values <4 are treated as 4.
- pat_out  out  CHANNELS  registered test pattern to pins.
- pat_in  in  CHANNELS  asynchronous looped-back pins.
- locked  out  CHANNELS  channel i is in LOCKED.
- err_count  out  CHANNELS*ERR_WIDTH  channel i occupies bits [i*ERR_WIDTH +: ERR_WIDTH]; saturating.

## Operation
- Divider: div_cnt counts 0..hp-1, where hp = max(half_period, 4). A tick is the cycle with div_cnt == hp-1. On a tick, div_cnt returns to 0. half_period is sampled each cycle; if a change leaves div_cnt ≥ hp-1, the tick fires on the next cycle.
- Pattern: phase is a CHANNELS-bit counter that increments on every tick and wraps modulo 2^CHANNELS. pat_out = phase, so channel i toggles every 2^i ticks. The distinct frequencies make shorts between channels visible.
- Sync: each pat_in bit passes through SYNC_STAGES flops to give sin[i].
- Check: on each tick, for each channel, match = (sin[i] == pat_out[i]). This compares against the value driven over the elapsed half-period, before the toggle.
- Per-channel FSM:
  - IDLE: entered whenever enable=0. Exits to SETTLE when enable=1.
  - SETTLE: ignores the first 2 ticks, then moves to ACQUIRE.
  - ACQUIRE: keeps a consecutive-match counter mcnt. A match increments mcnt; on reaching LOCK_COUNT the channel moves to LOCKED. A mismatch sets mcnt=0 and increments err.
  - LOCKED: a mismatch increments err, sets mcnt=0 and returns to ACQUIRE.
- Errors:
  - err_count saturates at 2^ERR_WIDTH-1.
  - clear has priority over a same-cycle increment; the result is 0.
  - err_count holds its value while enable=0.
- enable deasserted: div_cnt=0, phase=0, pat_out=0 on the next edge, all FSMs go to IDLE, mcnt=0.

## Timing
- Reset values: pat_out=0, locked=0, err_count=0, div_cnt=0, phase=0, FSMs in IDLE, synchronisers 0.
- The first edge with enable=1 starts div_cnt counting from 0. The first tick occurs hp cycles after that edge.
- pat_out changes one cycle after the tick cycle (registered).
- locked asserts one cycle after the tick that completes LOCK_COUNT matches. It deasserts one cycle after a mismatching tick.
- err_count updates one cycle after a mismatching tick; clear takes effect one cycle after its pulse.
- Minimum lock time after enable: (2+LOCK_COUNT)·hp + 1 cycles.
- Loopback delay tolerated: up to hp - SYNC_STAGES - 1 cycles.
- Asynchronous reset mid-run: all state returns to reset values immediately. After release, operation resumes only via IDLE→SETTLE.

## Test plan
- Reset and idle: assert reset_n=0 mid-run, then hold enable=0 → pat_out=0, locked=0, every err_count=0, with no toggles for 1000 cycles.
- Clean loopback (CHANNELS=4, half_period=16, LOCK_COUNT=8): pat_in=pat_out → pat_out[0] toggles every 16 cycles and pat_out[3] every 128 cycles; all locked bits go high 161 cycles after enable; err_count stays 0.
- Stuck pin: pat_in[2] tied to 0 → locked[2] stays 0; err_count[2] grows by 4 per 8 ticks; other channels lock with 0 errors.
- Crossed pins: pat_in[0] and pat_in[1] swapped → both channels register mismatches and never lock; channels 2 and 3 lock.
- Saturation and clear (ERR_WIDTH=4): channel 0 open (pat_in[0]=1) for 100 ticks → err_count[0]=15 and holds. A clear pulse on a mismatching tick → 0 the next cycle, then counting resumes.
- Clamp and re-lock:
  - half_period=1 → ticks every 4 cycles.
  - Inject one mismatching tick while LOCKED → locked drops for LOCK_COUNT ticks and err increments by exactly 1.
